instruction_memory_server: RTL and testbench

//  Memory-side responder for the InstructionFetch address/data interface.

---
 rtl/instruction_memory_server_if.sv | 30 +++
 rtl/instruction_memory_server.sv | 131 +++++++++++++
 tb/tb_instruction_memory_server.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/instruction_memory_server_if.sv
// Fetch/loader bus for instruction_memory_server.
//   master: fetch-side address and loader stimulus (driven by core/loader)
//   slave : memory-side responder (instruction_memory_server)
// Fetch group : address_to_memory, data_from_memory, out_of_range, core_hold
// Loader group: load_start, load_count, load_byte, load_valid, load_ready, load_done
interface instruction_memory_server_if #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] address_to_memory;
   logic [DATA_WIDTH-1:0] data_from_memory;
   logic                  out_of_range;
   logic                  core_hold;
   logic                  load_start;
   logic [ADDR_WIDTH-1:0] load_count;
   logic [7:0]            load_byte;
   logic                  load_valid;
   logic                  load_ready;
   logic                  load_done;

   modport master (
      output address_to_memory, load_start, load_count, load_byte, load_valid,
      input  data_from_memory, out_of_range, core_hold, load_ready, load_done
   );

   modport slave (
      input  address_to_memory, load_start, load_count, load_byte, load_valid,
      output data_from_memory, out_of_range, core_hold, load_ready, load_done
   );
endinterface

// File: rtl/instruction_memory_server.sv
// Instruction memory responder for the fetch stage with a byte-serial image loader.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - instruction_memory_server_if.slave: combinational fetch read path plus
//         valid/ready byte loader (big-endian, high byte first); core_hold stalls
//         fetch while an image is being loaded.
module instruction_memory_server #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 64
) (
   input logic                        clk,
   input logic                        rst,
   instruction_memory_server_if.slave bus
);
   localparam int unsigned IdxW = $clog2(DEPTH);
   // One extra bit so the pointer and target can hold DEPTH itself.
   localparam int unsigned PtrW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StLoadHi, StLoadLo, StDone} state_e;

   state_e                state_q, state_d;
   logic [PtrW-1:0]       ptr_q;
   logic [PtrW-1:0]       target_q, target_d;
   logic [7:0]            hi_q;
   logic [DEPTH-1:0]      valid_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  start_go, hi_we, lo_we;
   logic                  core_hold, load_ready, load_done;
   logic [ADDR_WIDTH-1:0] addr;
   logic [IdxW-1:0]       addr_idx, ptr_idx;
   logic                  out_of_range;

   assign addr         = bus.address_to_memory;
   assign addr_idx     = addr[IdxW-1:0];
   assign ptr_idx      = ptr_q[IdxW-1:0];
   assign out_of_range = 32'(addr) >= DEPTH;

   // Requests larger than the array are clamped to DEPTH words.
   always_comb begin
      target_d = PtrW'(bus.load_count);
      if (32'(bus.load_count) > DEPTH) begin
         target_d = PtrW'(DEPTH);
      end
   end

   always_comb begin
      state_d    = state_q;
      core_hold  = 1'b0;
      load_ready = 1'b0;
      load_done  = 1'b0;
      start_go   = 1'b0;
      hi_we      = 1'b0;
      lo_we      = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.load_start && (bus.load_count != '0)) begin
               start_go = 1'b1;
               state_d  = StLoadHi;
            end
         end
         StLoadHi: begin
            core_hold  = 1'b1;
            load_ready = 1'b1;
            if (bus.load_valid) begin
               hi_we   = 1'b1;
               state_d = StLoadLo;
            end
         end
         StLoadLo: begin
            core_hold  = 1'b1;
            load_ready = 1'b1;
            if (bus.load_valid) begin
               lo_we   = 1'b1;
               state_d = ((ptr_q + PtrW'(1)) == target_q) ? StDone : StLoadHi;
            end
         end
         StDone: begin
            core_hold = 1'b1;
            load_done = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         target_q <= '0;
         hi_q     <= '0;
         valid_q  <= '0;
      end else begin
         state_q <= state_d;
         if (start_go) begin
            ptr_q    <= '0;
            valid_q  <= '0;
            target_q <= target_d;
         end
         if (hi_we) begin
            hi_q <= bus.load_byte;
         end
         if (lo_we) begin
            valid_q[ptr_idx] <= 1'b1;
            ptr_q            <= ptr_q + PtrW'(1);
         end
      end
   end

   // Storage is not reset; validity is tracked by valid_q.
   always_ff @(posedge clk) begin
      if (lo_we && !rst) begin
         mem[ptr_idx] <= DATA_WIDTH'({hi_q, bus.load_byte});
      end
   end

   always_comb begin
      bus.data_from_memory = '0;
      if (!core_hold && !out_of_range && valid_q[addr_idx]) begin
         bus.data_from_memory = mem[addr_idx];
      end
   end

   assign bus.out_of_range = out_of_range;
   assign bus.core_hold    = core_hold;
   assign bus.load_ready   = load_ready;
   assign bus.load_done    = load_done;
endmodule

// File: tb/tb_instruction_memory_server.sv
// Self-checking bench for instruction_memory_server: directed scenarios followed by
// random traffic, all compared against a byte-counting reference model.
module tb_instruction_memory_server;
   localparam int Depth = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   instruction_memory_server_if bus ();

   instruction_memory_server dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a load is a count of accepted bytes against a word target.
   logic [15:0] m_mem [Depth];
   bit          m_valid [Depth];
   bit          m_busy = 0;
   bit          m_done = 0;
   bit          m_known = 0;
   int          m_nbytes = 0;
   int          m_target = 0;
   logic [7:0]  m_hi = 8'h00;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_data(input int a);
      if (m_busy || m_done || a >= Depth) return 16'h0000;
      if (!m_valid[a]) return 16'h0000;
      return m_mem[a];
   endfunction

   task automatic model_update(input bit r, input bit st, input int cnt, input logic [7:0] b,
                               input bit v);
      int w;
      if (r) begin
         m_busy  = 0;
         m_done  = 0;
         m_known = 1;
         for (int i = 0; i < Depth; i++) m_valid[i] = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_busy) begin
         if (v) begin
            if (m_nbytes % 2 == 0) begin
               m_hi = b;
            end else begin
               w = m_nbytes / 2;
               m_mem[w]   = {m_hi, b};
               m_valid[w] = 1;
               if (w + 1 == m_target) begin
                  m_busy = 0;
                  m_done = 1;
               end
            end
            m_nbytes++;
         end
      end else if (st && cnt != 0) begin
         m_busy   = 1;
         m_nbytes = 0;
         m_target = (cnt > Depth) ? Depth : cnt;
         for (int i = 0; i < Depth; i++) m_valid[i] = 0;
      end
   endtask

   task automatic cycle(input bit r, input bit st, input int cnt, input logic [7:0] b,
                        input bit v, input int a);
      @(negedge clk);
      rst                   = r;
      bus.load_start        = st;
      bus.load_count        = 14'(cnt);
      bus.load_byte         = b;
      bus.load_valid        = v;
      bus.address_to_memory = 14'(a);
      #1;
      if (m_known) begin
         check_eq("core_hold", 32'(bus.core_hold), 32'(m_busy || m_done));
         check_eq("load_ready", 32'(bus.load_ready), 32'(m_busy));
         check_eq("load_done", 32'(bus.load_done), 32'(m_done));
         check_eq("out_of_range", 32'(bus.out_of_range), 32'(a >= Depth));
         check_eq("data", 32'(bus.data_from_memory), 32'(exp_data(a)));
      end
      @(posedge clk);
      model_update(r, st, cnt, b, v);
   endtask

   task automatic idle(input int a);
      cycle(0, 0, 0, 8'($urandom), 0, a);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gaps);
      for (int g = 0; g < gaps; g++) cycle(0, 0, 0, 8'($urandom), 0, $urandom_range(0, 3));
      cycle(0, 0, 0, b, 1, $urandom_range(0, 3));
   endtask

   logic [7:0] img [6];
   int rc, cnt, a;

   initial begin
      img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56;
      img[3] = 8'h78; img[4] = 8'h9A; img[5] = 8'hBC;
      bus.load_start = 0; bus.load_count = '0; bus.load_byte = '0;
      bus.load_valid = 0; bus.address_to_memory = '0;

      // T1: reset then read address 5
      cycle(1, 0, 0, 8'h00, 0, 5);
      cycle(1, 0, 0, 8'h00, 0, 5);
      idle(5);

      // T2: 3-word load, back-to-back bytes
      cycle(0, 1, 3, 8'h00, 0, 0);
      for (int i = 0; i < 6; i++) send_byte(img[i], 0);
      for (int i = 0; i < 6; i++) idle(i % 4);
      check_eq("t2_word1", 32'(m_mem[1]), 32'h5678);

      // T3: same image with 3-cycle gaps between bytes
      cycle(0, 1, 3, 8'h00, 0, 0);
      for (int i = 0; i < 6; i++) send_byte(img[i], 3);
      for (int i = 0; i < 6; i++) idle(i % 4);

      // T4: range boundaries
      idle(100);
      idle(63);
      idle(64);
      idle(2);

      // T5: reset mid-load, then a full load
      cycle(0, 1, 4, 8'h00, 0, 0);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
      cycle(1, 0, 0, 8'h00, 0, 0);
      idle(0);
      cycle(0, 1, 4, 8'h00, 0, 0);
      for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
      for (int i = 0; i < 5; i++) idle(i);

      // T6: zero count ignored; oversize count clamped; start during load ignored
      cycle(0, 1, 0, 8'h00, 0, 0);
      idle(0);
      cycle(0, 1, 200, 8'h00, 0, 0);
      for (int i = 0; i < 128; i++) cycle(0, (i % 2) == 1, 5, 8'($urandom), 1, 0);
      for (int i = 0; i < Depth + 2; i++) idle(i);

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         rc = $urandom_range(0, 3);
         case (rc)
            0:       cnt = 0;
            1:       cnt = $urandom_range(1, 6);
            2:       cnt = $urandom_range(60, 70);
            default: cnt = $urandom_range(0, 16383);
         endcase
         a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16383) : $urandom_range(0, 66);
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, cnt, 8'($urandom),
               $urandom_range(0, 1) == 1, a);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
